// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised rxd, oversampled bit timing, 3-sample mid-bit majority vote.
// Latency ~9.6 bit times from start edge to strobe; no backpressure, consumer must take data on data_valid.
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLING);
    localparam int CW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLING);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLING - 1);
    localparam logic [SW-1:0] S_V0     = SW'(OVERSAMPLING / 2 - 1);
    localparam logic [SW-1:0] S_V1     = SW'(OVERSAMPLING / 2);
    localparam logic [SW-1:0] S_V2     = SW'(OVERSAMPLING / 2 + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] s_q, s_d;
    logic [1:0]    v_q, v_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;
    logic          fe_q, fe_d;
    logic          busy_q;

    logic tick, wrap, vote_done, vbit;

    assign tick      = (cnt_q == CNT_LAST);
    assign wrap      = tick && (s_q == S_LAST);
    assign vote_done = tick && (s_q == S_V2);
    // Third sample is taken live from rx_s so the decision lands on the same tick.
    assign vbit      = (v_q[0] & v_q[1]) | (v_q[0] & rx_s_q) | (v_q[1] & rx_s_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        v_d     = v_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            s_d     = '0;
        end else if (state_q == IDLE) begin
            cnt_d = '0;
            s_d   = '0;
            if (!rx_s_q) begin
                state_d = START;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
            end
            if (tick && s_q == S_V0) v_d[0] = rx_s_q;
            if (tick && s_q == S_V1) v_d[1] = rx_s_q;

            case (state_q)
                START: begin
                    if (vote_done && vbit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        s_d     = '0;
                    end else if (wrap) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (vote_done) begin
                        shift_d = {vbit, shift_q[7:1]};
                    end
                    if (wrap) begin
                        if (idx_q == 3'd7) state_d = STOP;
                        else               idx_d   = idx_q + 3'd1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a following start edge is never missed.
                    if (vote_done) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        s_d     = '0;
                        if (vbit) begin
                            data_d = shift_q;
                            dv_d   = 1'b1;
                        end else begin
                            fe_d   = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            s_q       <= '0;
            v_q       <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rxd;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            v_q       <= v_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign data        = data_q;
    assign data_valid  = dv_q;
    assign frame_error = fe_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 64 clocks per bit; a monitor records strobes, main flow checks results.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rxd;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    localparam int BIT_CLKS = 64;

    uart_rx #(
        .CLK_FREQ    (6400000),
        .BAUD        (100000),
        .OVERSAMPLING(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int         vld_cnt = 0;
    int         fe_cnt  = 0;
    int         both_cnt = 0;
    int         run_len = 0;
    int         max_run = 0;
    logic [7:0] rx_bytes[$];

    always @(negedge clk) begin
        if (data_valid) begin
            vld_cnt++;
            rx_bytes.push_back(data);
        end
        if (frame_error) fe_cnt++;
        if (data_valid && frame_error) both_cnt++;
        if (data_valid || frame_error) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        vld_cnt = 0;
        fe_cnt  = 0;
        rx_bytes.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // glitch_bit / abort_bit: data bit index 0..7, or -1 for none.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int glitch_bit, input int abort_bit);
        logic [9:0] frame;
        frame = {stop_val, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                @(negedge clk);
                if (abort_bit >= 0 && i == abort_bit + 1 && c == 32) return;
                rxd = frame[i];
                if (glitch_bit >= 0 && i == glitch_bit + 1 && c == 35) rxd = ~frame[i];
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        rxd    = 1'b1;
        idle(4);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_ferr", 32'(frame_error), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst    = 1'b0;
        enable = 1'b1;
        idle(10);

        clear_mon();
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(100);
        chk("a5_count", 32'(vld_cnt), 32'd1);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_ferr", 32'(fe_cnt), 32'd0);
        chk("a5_busy", 32'(busy), 32'h0);

        clear_mon();
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(100);
        chk("b2b_count", 32'(vld_cnt), 32'd3);
        if (rx_bytes.size() == 3) begin
            chk("b2b_0", 32'(rx_bytes[0]), 32'h00);
            chk("b2b_1", 32'(rx_bytes[1]), 32'hFF);
            chk("b2b_2", 32'(rx_bytes[2]), 32'h3C);
        end

        clear_mon();
        send_frame(8'h55, 1'b0, -1, -1);
        @(negedge clk);
        rxd = 1'b1;
        idle(200);
        chk("ferr_count", 32'(fe_cnt), 32'd1);
        chk("ferr_novalid", 32'(vld_cnt), 32'd0);
        chk("ferr_data", 32'(data), 32'h3C);

        clear_mon();
        rxd = 1'b0;
        idle(20);
        rxd = 1'b1;
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        idle(100);
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        chk("glitch_nostrobe", 32'(vld_cnt + fe_cnt), 32'd0);

        clear_mon();
        send_frame(8'h0F, 1'b1, 3, -1);
        idle(100);
        chk("vote_count", 32'(vld_cnt), 32'd1);
        chk("vote_data", 32'(data), 32'h0F);

        clear_mon();
        send_frame(8'hC3, 1'b1, -1, 4);
        enable = 1'b0;
        rxd    = 1'b1;
        idle(2);
        chk("en_busy", 32'(busy), 32'h0);
        idle(100);
        enable = 1'b1;
        idle(10);
        chk("en_nostrobe", 32'(vld_cnt + fe_cnt), 32'd0);
        send_frame(8'h81, 1'b1, -1, -1);
        idle(100);
        chk("en_count", 32'(vld_cnt), 32'd1);
        chk("en_data", 32'(data), 32'h81);

        clear_mon();
        send_frame(8'hC3, 1'b1, -1, 4);
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_data", 32'(data), 32'h00);
        idle(3);
        rst = 1'b0;
        idle(100);
        chk("rstmid_nostrobe", 32'(vld_cnt + fe_cnt), 32'd0);
        send_frame(8'h81, 1'b1, -1, -1);
        idle(100);
        chk("rstmid_count", 32'(vld_cnt), 32'd1);
        chk("rstmid_data2", 32'(data), 32'h81);

        chk("never_both", 32'(both_cnt), 32'd0);
        chk("strobe_width", 32'(max_run), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
